// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer between the MEM stage and the dmem port.
// One access per request: latch, request, wait for response (with watchdog), release.
module dmem_access_ctrl #(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                cpu_valid,
  input  logic                cpu_we,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic [DATA_W/8-1:0] cpu_wmask,
  output logic                cpu_stall,
  output logic                cpu_done,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                cpu_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_we,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_rdata
);

  localparam int unsigned MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;

  // Byte offset within the doubleword is dropped; memory always sees aligned requests.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^cpu_addr[2:0];

  assign cpu_stall = cpu_valid & ~cpu_done;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state         <= S_IDLE;
      wait_cnt      <= '0;
      cpu_done      <= 1'b0;
      cpu_rdata     <= '0;
      cpu_err       <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_we    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      mem_req_wmask <= '0;
    end else begin
      cpu_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cpu_valid) begin
            mem_req_valid <= 1'b1;
            mem_req_we    <= cpu_we;
            mem_req_addr  <= {cpu_addr[ADDR_W-1:3], 3'b000};
            mem_req_wdata <= cpu_wdata;
            mem_req_wmask <= cpu_we ? cpu_wmask : MASK_W'(0);
            state         <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            wait_cnt      <= '0;
            state         <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_resp_valid) begin
            if (!mem_req_we) begin
              cpu_rdata <= mem_resp_rdata;
            end
            cpu_err  <= 1'b0;
            cpu_done <= 1'b1;
            state    <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
            // Watchdog: abort after TIMEOUT cycles without a response.
            if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
              cpu_err   <= 1'b1;
              cpu_rdata <= '0;
              cpu_done  <= 1'b1;
              state     <= S_DONE;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed scenarios plus randomized
// accesses compared against a cycle-count/latency model of the access protocol.
module tb_dmem_access_ctrl;

  localparam int TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cpu_valid;
  logic        cpu_we;
  logic [63:0] cpu_addr;
  logic [63:0] cpu_wdata;
  logic [7:0]  cpu_wmask;
  logic        cpu_stall;
  logic        cpu_done;
  logic [63:0] cpu_rdata;
  logic        cpu_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [63:0] mem_req_addr;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_rdata;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int cyc      = 0;

  dmem_access_ctrl #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .clk(clk), .rstn(rstn),
    .cpu_valid(cpu_valid), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wmask(cpu_wmask),
    .cpu_stall(cpu_stall), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected done cycle relative to the accept cycle.
  function automatic int exp_done(input int rd, input int rsd, input bit never);
    if (never || rsd >= TIMEOUT) return 2 + rd + TIMEOUT;
    return 3 + rd + rsd;
  endfunction

  // Plays MEM stage and memory for one access; starts and returns just after a rising edge.
  task automatic run_access(
    input  logic        we, input logic [63:0] addr, input logic [63:0] wdata,
    input  logic [7:0]  wmask, input int rd, input int rsd, input logic [63:0] rdat,
    input  bit never, input bit noise, input bit chg_addr, input bit keep_valid,
    output int done_t, output int done_abs, output logic [63:0] o_rdata, output logic o_err,
    output logic [63:0] o_addr, output logic [63:0] o_wdata, output logic [7:0] o_wmask,
    output logic o_we, output int stall_n, output bit stable, output bit stall_done_ok);
    int  req_cnt = 0;
    int  w_cnt   = 0;
    bit  acc     = 0;
    bit  seen    = 0;
    cpu_valid = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_wmask = wmask;
    done_t = -1; done_abs = -1; stall_n = 0; stable = 1'b1; stall_done_ok = 1'b0;
    o_rdata = '0; o_err = 1'b0; o_addr = '0; o_wdata = '0; o_wmask = '0; o_we = 1'b0;
    for (int t = 0; t < 600; t++) begin
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      if (!acc) begin
        if (mem_req_valid) mem_req_ready = (req_cnt >= rd);
        if (noise) begin
          mem_resp_valid = 1'($urandom_range(0, 1));
          mem_resp_rdata = {$urandom, $urandom};
        end
      end else if (!never && w_cnt == rsd) begin
        mem_resp_valid = 1'b1;
        mem_resp_rdata = rdat;
      end
      if (chg_addr && mem_req_valid) cpu_addr = {$urandom, $urandom};
      #1;
      if (cpu_stall) stall_n++;
      if (mem_req_valid) begin
        if (!seen) begin
          seen = 1'b1; o_addr = mem_req_addr; o_wdata = mem_req_wdata;
          o_wmask = mem_req_wmask; o_we = mem_req_we;
        end else if (o_addr !== mem_req_addr || o_wdata !== mem_req_wdata ||
                     o_wmask !== mem_req_wmask || o_we !== mem_req_we) begin
          stable = 1'b0;
        end
      end
      if (cpu_done) begin
        done_t = t; done_abs = cyc; o_rdata = cpu_rdata; o_err = cpu_err;
        stall_done_ok = (cpu_stall === 1'b0);
      end
      if (acc) w_cnt++;
      if (!acc && mem_req_valid) begin
        if (mem_req_ready) acc = 1'b1;
        req_cnt++;
      end
      @(posedge clk); #1;
      if (done_t >= 0) break;
    end
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    if (!keep_valid) cpu_valid = 1'b0;
  endtask

  int          d_t, d_abs, st_n;
  logic [63:0] r_data, r_addr, r_wdata;
  logic [7:0]  r_wmask;
  logic        r_err, r_we;
  bit          r_stable, r_sd_ok;

  task automatic test_reset();
    rstn = 1'b0; cpu_valid = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    cpu_wmask = '0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_cnt++;
    if ({cpu_stall, cpu_done, cpu_err, mem_req_valid, mem_req_we, cpu_rdata, mem_req_addr,
         mem_req_wdata, mem_req_wmask} !== '0) begin
      $display("FAIL reset_outputs: got done=%b err=%b req_valid=%b rdata=%h addr=%h, required all 0",
               cpu_done, cpu_err, mem_req_valid, cpu_rdata, mem_req_addr);
    end else pass_cnt++;
    rstn = 1'b1;
    @(posedge clk); #1;
    chk_cnt++;
    if ({cpu_done, mem_req_valid} !== 2'b00) begin
      $display("FAIL reset_idle: got done=%b req_valid=%b, required 0 0", cpu_done, mem_req_valid);
    end else pass_cnt++;
  endtask

  task automatic test_store();
    run_access(1'b1, 64'h1004, 64'hDEADBEEF_00000000, 8'hF0, 0, 0, 64'h0, 0, 0, 0, 0,
               d_t, d_abs, r_data, r_err, r_addr, r_wdata, r_wmask, r_we, st_n, r_stable, r_sd_ok);
    chk_cnt++;
    if (d_t !== 3) $display("FAIL store_latency: got %0d required 3", d_t); else pass_cnt++;
    chk_cnt++;
    if (r_addr !== 64'h1000 || r_wmask !== 8'hF0 || r_wdata !== 64'hDEADBEEF_00000000 || r_we !== 1'b1)
      $display("FAIL store_req: got addr=%h mask=%h data=%h we=%b required 1000 f0 deadbeef00000000 1",
               r_addr, r_wmask, r_wdata, r_we);
    else pass_cnt++;
    chk_cnt++;
    if (r_err !== 1'b0 || st_n !== 3 || !r_sd_ok)
      $display("FAIL store_err_stall: got err=%b stall_cycles=%0d stall_in_done_ok=%0d required 0 3 1",
               r_err, st_n, r_sd_ok);
    else pass_cnt++;
  endtask

  task automatic test_load();
    run_access(1'b0, 64'h2008, 64'h1111, 8'hFF, 3, 2, 64'h0123456789ABCDEF, 0, 0, 0, 0,
               d_t, d_abs, r_data, r_err, r_addr, r_wdata, r_wmask, r_we, st_n, r_stable, r_sd_ok);
    chk_cnt++;
    if (d_t !== 8) $display("FAIL load_latency: got %0d required 8", d_t); else pass_cnt++;
    chk_cnt++;
    if (r_data !== 64'h0123456789ABCDEF || r_err !== 1'b0)
      $display("FAIL load_rdata: got %h err=%b required 0123456789abcdef 0", r_data, r_err);
    else pass_cnt++;
    chk_cnt++;
    if (st_n !== 8 || !r_sd_ok || r_wmask !== 8'h00 || r_we !== 1'b0)
      $display("FAIL load_stall_mask: got stall_cycles=%0d done_ok=%0d mask=%h we=%b required 8 1 00 0",
               st_n, r_sd_ok, r_wmask, r_we);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    int late_done = 0;
    run_access(1'b0, 64'h3000, 64'h0, 8'h00, 1, 0, 64'h0, 1, 1, 0, 0,
               d_t, d_abs, r_data, r_err, r_addr, r_wdata, r_wmask, r_we, st_n, r_stable, r_sd_ok);
    chk_cnt++;
    if (d_t !== exp_done(1, 0, 1) || r_err !== 1'b1 || r_data !== 64'h0)
      $display("FAIL timeout: got done_t=%0d err=%b rdata=%h required %0d 1 0",
               d_t, r_err, r_data, exp_done(1, 0, 1));
    else pass_cnt++;
    mem_resp_valid = 1'b1; mem_resp_rdata = 64'hFFFF;
    for (int i = 0; i < 5; i++) begin
      if (cpu_done || mem_req_valid) late_done++;
      @(posedge clk); #1;
    end
    mem_resp_valid = 1'b0;
    chk_cnt++;
    if (late_done !== 0) $display("FAIL timeout_idle_resp: got %0d active cycles required 0", late_done);
    else pass_cnt++;
  endtask

  task automatic test_resp_last_cycle();
    run_access(1'b0, 64'h4010, 64'h0, 8'h00, 0, TIMEOUT - 1, 64'hA5A5_5A5A_0F0F_F0F0, 0, 0, 0, 0,
               d_t, d_abs, r_data, r_err, r_addr, r_wdata, r_wmask, r_we, st_n, r_stable, r_sd_ok);
    chk_cnt++;
    if (d_t !== exp_done(0, TIMEOUT - 1, 0) || r_err !== 1'b0 || r_data !== 64'hA5A5_5A5A_0F0F_F0F0)
      $display("FAIL resp_last_cycle: got done_t=%0d err=%b rdata=%h required %0d 0 a5a55a5a0f0ff0f0",
               d_t, r_err, r_data, exp_done(0, TIMEOUT - 1, 0));
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_wait();
    int late_done = 0;
    cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 64'h5555; cpu_wdata = 64'h77; cpu_wmask = 8'h0F;
    mem_req_ready = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    mem_req_ready = 1'b0;
    cpu_valid = 1'b0;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    chk_cnt++;
    if ({cpu_done, cpu_err, mem_req_valid, mem_req_we, cpu_rdata, mem_req_addr,
         mem_req_wdata, mem_req_wmask} !== '0)
      $display("FAIL reset_mid_wait: got err=%b req_valid=%b addr=%h wdata=%h mask=%h required all 0",
               cpu_err, mem_req_valid, mem_req_addr, mem_req_wdata, mem_req_wmask);
    else pass_cnt++;
    mem_resp_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (cpu_done) late_done++;
      @(posedge clk); #1;
    end
    mem_resp_valid = 1'b0;
    chk_cnt++;
    if (late_done !== 0) $display("FAIL reset_late_resp: got %0d done pulses required 0", late_done);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int          abs1;
    logic [63:0] addr2 = 64'h6ABC;
    run_access(1'b0, 64'h6000, 64'h0, 8'h00, 0, 0, 64'h1111_2222_3333_4444, 0, 0, 0, 1,
               d_t, abs1, r_data, r_err, r_addr, r_wdata, r_wmask, r_we, st_n, r_stable, r_sd_ok);
    run_access(1'b0, addr2, 64'h0, 8'h00, 0, 0, 64'h5555_6666_7777_8888, 0, 0, 0, 0,
               d_t, d_abs, r_data, r_err, r_addr, r_wdata, r_wmask, r_we, st_n, r_stable, r_sd_ok);
    chk_cnt++;
    if (abs1 < 0 || d_abs - abs1 !== 4)
      $display("FAIL back_to_back_gap: got %0d cycles required 4", d_abs - abs1);
    else pass_cnt++;
    chk_cnt++;
    if (r_data !== 64'h5555_6666_7777_8888 || r_addr !== {addr2[63:3], 3'b000})
      $display("FAIL back_to_back_second: got rdata=%h addr=%h required 5555666677778888 %h",
               r_data, r_addr, {addr2[63:3], 3'b000});
    else pass_cnt++;
  endtask

  task automatic test_addr_change();
    run_access(1'b1, 64'h7777_0000_0000_123F, 64'hCAFE, 8'h3C, 3, 1, 64'h0, 0, 1, 1, 0,
               d_t, d_abs, r_data, r_err, r_addr, r_wdata, r_wmask, r_we, st_n, r_stable, r_sd_ok);
    chk_cnt++;
    if (!r_stable || r_addr !== 64'h7777_0000_0000_1238 || d_t !== exp_done(3, 1, 0))
      $display("FAIL addr_change_in_req: got stable=%0d addr=%h done_t=%0d required 1 7777000000001238 %0d",
               r_stable, r_addr, d_t, exp_done(3, 1, 0));
    else pass_cnt++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 16; n++) begin
      logic        we    = 1'($urandom_range(0, 1));
      logic [63:0] addr  = {$urandom, $urandom};
      logic [63:0] wdata = {$urandom, $urandom};
      logic [7:0]  wmask = 8'($urandom);
      logic [63:0] rdat  = {$urandom, $urandom};
      int          rd    = $urandom_range(0, 4);
      int          rsd   = $urandom_range(0, 4);
      run_access(we, addr, wdata, wmask, rd, rsd, rdat, 0, 1, 0, 0,
                 d_t, d_abs, r_data, r_err, r_addr, r_wdata, r_wmask, r_we, st_n, r_stable, r_sd_ok);
      chk_cnt++;
      if (d_t !== exp_done(rd, rsd, 0) || r_err !== 1'b0 || st_n !== d_t)
        $display("FAIL rand%0d_timing: got done_t=%0d err=%b stall=%0d required %0d 0 %0d",
                 n, d_t, r_err, st_n, exp_done(rd, rsd, 0), exp_done(rd, rsd, 0));
      else pass_cnt++;
      chk_cnt++;
      if (r_addr !== {addr[63:3], 3'b000} || r_we !== we || r_wdata !== wdata ||
          r_wmask !== (we ? wmask : 8'h00) || !r_stable)
        $display("FAIL rand%0d_req: got addr=%h we=%b data=%h mask=%h required %h %b %h %h",
                 n, r_addr, r_we, r_wdata, r_wmask, {addr[63:3], 3'b000}, we, wdata,
                 we ? wmask : 8'h00);
      else pass_cnt++;
      if (!we) begin
        chk_cnt++;
        if (r_data !== rdat) $display("FAIL rand%0d_rdata: got %h required %h", n, r_data, rdat);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_timeout();
    test_resp_last_cycle();
    test_reset_mid_wait();
    test_back_to_back();
    test_addr_change();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
